// File: rtl/score_jk_driver_if.sv
// score_jk_driver_if: command handshake plus JK bank excitation/feedback bundle.
interface score_jk_driver_if #(parameter int WIDTH = 8);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_dec;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             ff_clr;
  logic             busy;
  logic             err;
  logic [WIDTH-1:0] target;
  modport master (
    input  cmd_valid, cmd_op, cmd_dec, q_fb,
    output cmd_ready, j_vec, k_vec, ff_clr, busy, err, target
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_dec, q_fb,
    input  cmd_ready, j_vec, k_vec, ff_clr, busy, err, target
  );
endinterface

// File: rtl/score_jk_driver.sv
// score_jk_driver: turns point commands into one-cycle J/K excitation of an external
// flip-flop score bank, verifying the readback and retrying before flagging an error.
module score_jk_driver #(
  parameter int WIDTH     = 8,
  parameter int MAX_SCORE = 199,
  parameter int MAX_RETRY = 2
) (
  input logic               clk,
  input logic               clr,
  score_jk_driver_if.master bus
);
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  typedef enum logic [2:0] {IDLE, COMPUTE, DRIVE, VERIFY, ERROR} state_t;
  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             dec_q, dec_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] amt, calc;
  logic [WIDTH:0]   sum;
  logic             drive, clr_op;
  assign amt  = WIDTH'(op_q);
  assign sum  = {1'b0, bus.q_fb} + {1'b0, amt};
  // both directions clamp instead of wrapping
  assign calc = (op_q == 2'b00) ? '0 :
                dec_q ? ((bus.q_fb < amt) ? '0 : bus.q_fb - amt) :
                (sum > (WIDTH+1)'(MAX_SCORE)) ? WIDTH'(MAX_SCORE) : sum[WIDTH-1:0];
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      dec_q    <= 1'b0;
      target_q <= '0;
      retry_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dec_q    <= dec_d;
      target_q <= target_d;
      retry_q  <= retry_d;
      err_q    <= err_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dec_d    = dec_q;
    target_d = target_q;
    retry_d  = retry_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        op_d    = bus.cmd_op;
        dec_d   = bus.cmd_dec;
        retry_d = '0;
        state_d = COMPUTE;
      end
      COMPUTE: begin
        target_d = calc;
        state_d  = (calc == bus.q_fb) ? IDLE : DRIVE;
      end
      DRIVE: state_d = VERIFY;
      VERIFY: if (bus.q_fb == target_q) state_d = IDLE;
        else if (retry_q == RW'(MAX_RETRY)) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end else begin
          retry_d = retry_q + 1'b1;
          state_d = DRIVE;
        end
      ERROR: state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end
  // excitation is purely a decode of DRIVE, so an async clear silences it immediately
  assign drive         = state_q == DRIVE;
  assign clr_op        = op_q == 2'b00;
  assign bus.j_vec     = (drive && !clr_op) ? (~bus.q_fb & target_q) : '0;
  assign bus.k_vec     = (drive && !clr_op) ? (bus.q_fb & ~target_q) : '0;
  assign bus.ff_clr    = drive && clr_op;
  assign bus.cmd_ready = state_q == IDLE;
  assign bus.busy      = (state_q != IDLE) && (state_q != ERROR);
  assign bus.err       = err_q;
  assign bus.target    = target_q;
endmodule

// File: tb/tb_score_jk_driver.sv
// tb_score_jk_driver: directed scenarios against a behavioural JK flip-flop bank.
module tb_score_jk_driver;
  logic clk = 1'b0;
  logic clr = 1'b1;
  score_jk_driver_if #(.WIDTH(8)) bus ();
  score_jk_driver #(.WIDTH(8), .MAX_SCORE(199), .MAX_RETRY(2)) dut (.clk(clk), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] bank, load_val;
  logic       load_en = 1'b0, stuck = 1'b0;
  always @(posedge clk)
    if (load_en) bank <= load_val;
    else if (!stuck) bank <= bus.ff_clr ? 8'h00 : ((bus.j_vec & ~bank) | (~bus.k_vec & bank));
  assign bus.q_fb = bank;
  int passed = 0, total = 0;
  int r_cycles, r_drives, r_pulses;
  logic [7:0] r_j, r_k;
  task automatic preload(input logic [7:0] v);
    @(negedge clk);
    load_val = v;
    load_en  = 1'b1;
    @(negedge clk);
    load_en  = 1'b0;
  endtask
  task automatic run(input logic [1:0] op, input logic d);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_dec   = d;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    r_drives = 0; r_pulses = 0; r_j = 8'h00; r_k = 8'h00; r_cycles = 0;
    @(negedge clk);
    while (!bus.cmd_ready && !bus.err && r_cycles < 20) begin
      if (bus.j_vec != 0 || bus.k_vec != 0 || bus.ff_clr) begin
        if (r_drives == 0) begin r_j = bus.j_vec; r_k = bus.k_vec; end
        r_drives++;
      end
      if (bus.ff_clr) r_pulses++;
      @(negedge clk);
      r_cycles++;
    end
    total++; if (!(bus.cmd_ready || bus.err)) $display("FAIL run_timeout: op=%0d dec=%0b no completion after %0d cycles", op, d, r_cycles); else passed++;
  endtask
  task automatic test_reset();
    load_val = 8'h00; load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    total++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); else passed++;
    total++; if ({bus.busy, bus.err, bus.ff_clr} !== 3'b000) $display("FAIL reset_flags: busy/err/ff_clr got %b want 000", {bus.busy, bus.err, bus.ff_clr}); else passed++;
    total++; if ({bus.target, bus.j_vec, bus.k_vec} !== 24'h0) $display("FAIL reset_vecs: target/j/k got %h want 000000", {bus.target, bus.j_vec, bus.k_vec}); else passed++;
    clr = 1'b0;
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", bus.cmd_ready); else passed++;
  endtask
  task automatic test_add();
    preload(8'd5);
    run(2'b10, 1'b0);
    total++; if (r_cycles !== 3) $display("FAIL add_latency: got %0d want 3", r_cycles); else passed++;
    total++; if (r_drives !== 1) $display("FAIL add_drives: got %0d want 1", r_drives); else passed++;
    total++; if ({r_j, r_k} !== 16'h0200) $display("FAIL add_jk: got j=%h k=%h want j=02 k=00", r_j, r_k); else passed++;
    total++; if (bus.target !== 8'd7) $display("FAIL add_target: got %0d want 7", bus.target); else passed++;
    total++; if (bank !== 8'd7) $display("FAIL add_bank: got %0d want 7", bank); else passed++;
  endtask
  task automatic test_saturate();
    preload(8'd198);
    run(2'b11, 1'b0);
    total++; if (bus.target !== 8'd199) $display("FAIL sat_target: got %0d want 199", bus.target); else passed++;
    total++; if ({r_j, r_k} !== 16'h0100) $display("FAIL sat_jk: got j=%h k=%h want j=01 k=00", r_j, r_k); else passed++;
    total++; if (bank !== 8'd199) $display("FAIL sat_bank: got %0d want 199", bank); else passed++;
    run(2'b01, 1'b0);
    total++; if (r_drives !== 0) $display("FAIL sat_nodrive: drives got %0d want 0", r_drives); else passed++;
    total++; if (r_cycles !== 1) $display("FAIL sat_latency: got %0d want 1", r_cycles); else passed++;
    total++; if (bus.target !== 8'd199) $display("FAIL sat_hold: got %0d want 199", bus.target); else passed++;
  endtask
  task automatic test_dec_and_clear();
    preload(8'd1);
    run(2'b10, 1'b1);
    total++; if (bus.target !== 8'd0) $display("FAIL dec_target: got %0d want 0", bus.target); else passed++;
    total++; if ({r_j, r_k} !== 16'h0001) $display("FAIL dec_jk: got j=%h k=%h want j=00 k=01", r_j, r_k); else passed++;
    total++; if (bank !== 8'd0) $display("FAIL dec_bank: got %0d want 0", bank); else passed++;
    run(2'b11, 1'b1);
    total++; if (r_drives !== 0) $display("FAIL dec_floor_nodrive: drives got %0d want 0", r_drives); else passed++;
    preload(8'h5A);
    run(2'b00, 1'b0);
    total++; if (r_pulses !== 1) $display("FAIL clr_pulse: ff_clr cycles got %0d want 1", r_pulses); else passed++;
    total++; if ({r_j, r_k} !== 16'h0000) $display("FAIL clr_jk: got j=%h k=%h want 00 00", r_j, r_k); else passed++;
    total++; if (bank !== 8'd0) $display("FAIL clr_bank: got %h want 00", bank); else passed++;
  endtask
  task automatic test_retry_error();
    int seen_ready;
    preload(8'd10);
    stuck = 1'b1;
    run(2'b01, 1'b0);
    total++; if (r_drives !== 3) $display("FAIL retry_drives: got %0d want 3", r_drives); else passed++;
    total++; if (r_cycles !== 7) $display("FAIL retry_cycles: got %0d want 7", r_cycles); else passed++;
    total++; if ({bus.err, bus.busy, bus.cmd_ready} !== 3'b100) $display("FAIL error_state: err/busy/ready got %b want 100", {bus.err, bus.busy, bus.cmd_ready}); else passed++;
    bus.cmd_valid = 1'b1;
    seen_ready = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.cmd_ready || bus.busy || !bus.err || bus.j_vec != 0 || bus.k_vec != 0 || bus.ff_clr) seen_ready++;
    end
    bus.cmd_valid = 1'b0;
    total++; if (seen_ready !== 0) $display("FAIL error_ignores_cmd: active cycles got %0d want 0", seen_ready); else passed++;
    stuck = 1'b0;
    clr = 1'b1;
    #1 clr = 1'b0;
    @(negedge clk);
    total++; if ({bus.err, bus.cmd_ready} !== 2'b01) $display("FAIL error_clr: err/ready got %b want 01", {bus.err, bus.cmd_ready}); else passed++;
    total++; if (bank !== 8'd10) $display("FAIL clr_keeps_bank: got %0d want 10", bank); else passed++;
  endtask
  task automatic test_clr_in_drive();
    preload(8'd20);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_dec = 1'b0;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.j_vec !== 8'h01) $display("FAIL abort_drive_seen: j got %h want 01", bus.j_vec); else passed++;
    #1 clr = 1'b1;
    #1;
    total++; if ({bus.j_vec, bus.k_vec, bus.ff_clr, bus.busy} !== 18'h0) $display("FAIL abort_outputs: j=%h k=%h ff_clr=%b busy=%b want all 0", bus.j_vec, bus.k_vec, bus.ff_clr, bus.busy); else passed++;
    total++; if ({bus.target, bus.cmd_ready} !== 9'h001) $display("FAIL abort_state: target=%0d ready=%b want 0/1", bus.target, bus.cmd_ready); else passed++;
    #1 clr = 1'b0;
    @(negedge clk);
    total++; if (bank !== 8'd20) $display("FAIL abort_bank: got %0d want 20", bank); else passed++;
    run(2'b01, 1'b0);
    total++; if (r_cycles !== 3 || bank !== 8'd21) $display("FAIL abort_next_cmd: cycles=%0d bank=%0d want 3/21", r_cycles, bank); else passed++;
  endtask
  task automatic test_back_to_back();
    int accepts, overlap;
    preload(8'd0);
    accepts = 0; overlap = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_dec = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.cmd_ready) accepts++;
      if (bus.cmd_ready && bus.busy) overlap++;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    total++; if (accepts !== 3) $display("FAIL b2b_accepts: got %0d want 3", accepts); else passed++;
    total++; if (overlap !== 0) $display("FAIL b2b_ready_busy: got %0d want 0", overlap); else passed++;
    total++; if (bank !== 8'd3) $display("FAIL b2b_bank: got %0d want 3", bank); else passed++;
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_dec   = 1'b0;
    test_reset();
    test_add();
    test_saturate();
    test_dec_and_clear();
    test_retry_error();
    test_clr_in_drive();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
